// File: rtl/gate_array_sched.sv
// Round-robin share of one bitwise gate array (AND/OR/XOR/NAND) among four requesters.
// Latency: 1 cycle from accept to rsp_valid; full throughput when the consumer drains each cycle.
// Backpressure: a full slot with rsp_ready low drops every req_ready; GATE_ARRAY_SCHED_STATS_EN adds ops_count.
module gate_array_sched #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_valid,
  output logic [3:0]         req_ready,
  input  logic [7:0]         req_op,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_id,
  output logic [WIDTH-1:0]   rsp_data
`ifdef GATE_ARRAY_SCHED_STATS_EN
  ,
  output logic [15:0]        ops_count
`endif
);

  logic [1:0]       last_gnt;
  logic [1:0]       winner;
  logic             any_vld;
  logic             can_accept;
  logic             accept;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] gate_dat;

  // Scan from lowest to highest priority so the nearest requester after last_gnt wins.
  always_comb begin
    logic [1:0] idx;
    idx     = '0;
    winner  = '0;
    any_vld = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_gnt + 2'(k);
      if (req_valid[idx]) begin
        winner  = idx;
        any_vld = 1'b1;
      end
    end
  end

  assign can_accept = !rsp_valid || rsp_ready;

  always_comb begin
    req_ready = 4'b0000;
    if (rst_n && any_vld && can_accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign accept = |req_ready;
  assign op_sel = req_op[2*winner +: 2];
  assign opa    = req_a[winner*WIDTH +: WIDTH];
  assign opb    = req_b[winner*WIDTH +: WIDTH];

  always_comb begin
    gate_dat = '0;
    case (op_sel)
      2'b00:   gate_dat = opa & opb;
      2'b01:   gate_dat = opa | opb;
      2'b10:   gate_dat = opa ^ opb;
      default: gate_dat = ~(opa & opb);
    endcase
  end

  // Drain and reload may coincide; the reload wins and the slot stays full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 2'd0;
      rsp_data  <= '0;
      last_gnt  <= 2'd3;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= winner;
      rsp_data  <= gate_dat;
      last_gnt  <= winner;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef GATE_ARRAY_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_count <= 16'd0;
    end else if (rsp_valid && rsp_ready && ops_count != 16'hFFFF) begin
      ops_count <= ops_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_array_sched.sv
// Bench for gate_array_sched: directed steps plus random traffic against a behavioural model.
module tb_gate_array_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
`ifdef GATE_ARRAY_SCHED_STATS_EN
  logic [15:0] ops_count;
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural model of the scheduler state
  int          m_last;
  bit          m_vld;
  int          m_id;
  logic [15:0] m_data;
  int          m_cnt;
  int          last_acc;

  always #5 clk = ~clk;

  gate_array_sched #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef GATE_ARRAY_SCHED_STATS_EN
    ,
    .ops_count (ops_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] gate(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // First valid requester after the last grant, or -1 when nobody asks.
  function automatic int pick();
    for (int k = 1; k <= 4; k++) begin
      if (req_valid[(m_last + k) % 4]) return (m_last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 3; m_vld = 0; m_id = 0; m_data = 16'h0; m_cnt = 0; last_acc = -1;
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model, return at posedge+1.
  task automatic cyc();
    int         w;
    logic [3:0] exp_rdy;
    @(negedge clk);
    check("rsp_valid", 64'(rsp_valid), 64'(m_vld));
    check("rsp_id", 64'(rsp_id), 64'(m_id));
    check("rsp_data", 64'(rsp_data), 64'(m_data));
`ifdef GATE_ARRAY_SCHED_STATS_EN
    check("ops_count", 64'(ops_count), 64'(m_cnt));
`endif
    w = pick();
    exp_rdy = 4'b0000;
    if (w >= 0 && (!m_vld || rsp_ready)) exp_rdy[w] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (m_vld && rsp_ready && m_cnt < 65535) m_cnt++;
    last_acc = -1;
    if (exp_rdy != 4'b0000) begin
      m_data   = gate(req_op[2*w +: 2], req_a[16*w +: 16], req_b[16*w +: 16]);
      m_id     = w;
      m_vld    = 1;
      m_last   = w;
      last_acc = w;
    end else if (m_vld && rsp_ready) begin
      m_vld = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 4'b1111; req_op = 8'h00; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    model_reset();
    #12;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_id", 64'(rsp_id), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 4'b0000;
    cyc();

    // Single op on requester 0
    req_valid = 4'b0001; req_op = 8'h00; req_a[15:0] = 16'hF0F0; req_b[15:0] = 16'hFF00;
    #1;
    check("single_req_ready", 64'(req_ready), 64'h1);
    cyc();
    req_valid = 4'b0000;
    check("single_rsp_valid", 64'(rsp_valid), 64'd1);
    check("single_rsp_id", 64'(rsp_id), 64'd0);
    check("single_rsp_data", 64'(rsp_data), 64'hF000);

    // Op coverage on requester 2
    req_a[47:32] = 16'hAAAA; req_b[47:32] = 16'h0FF0;
    req_valid = 4'b0100; req_op[5:4] = 2'b01; cyc();
    check("or_data", 64'(rsp_data), 64'hAFFA);
    check("or_id", 64'(rsp_id), 64'd2);
    req_op[5:4] = 2'b10; cyc();
    check("xor_data", 64'(rsp_data), 64'hA55A);
    req_op[5:4] = 2'b11; cyc();
    check("nand_data", 64'(rsp_data), 64'hF55F);
    check("nand_id", 64'(rsp_id), 64'd2);

    // Back-pressure: slot full, consumer stalls for five cycles
    rsp_ready = 1'b0; req_valid = 4'b1111;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_req_ready", 64'(req_ready), 64'h0);
      cyc();
    end
    check("bp_hold_data", 64'(rsp_data), 64'hF55F);
    rsp_ready = 1'b1;
    cyc();
    check("bp_drain_valid", 64'(rsp_valid), 64'd1);

    // Reset in the middle of traffic, then round-robin from a clean pointer
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'h0);
    model_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("rr_id", 64'(rsp_id), 64'(i % 4));
      check("rr_valid", 64'(rsp_valid), 64'd1);
    end

    // Random traffic; a requester only changes its request after being served or while idle
    req_valid = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] || i == last_acc) begin
          req_valid[i]       = 1'($urandom_range(0, 1));
          req_op[2*i +: 2]   = 2'($urandom_range(0, 3));
          req_a[16*i +: 16]  = 16'($urandom);
          req_b[16*i +: 16]  = 16'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

`ifdef GATE_ARRAY_SCHED_STATS_EN
    req_valid = 4'b0001; rsp_ready = 1'b1;
    for (int n = 0; n < 65540; n++) cyc();
    check("ops_sat", 64'(ops_count), 64'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
